sha256_digest_serializer: RTL and testbench
===========================================

Name: sha256_digest_serializer

Overview:
Downstream stage of the SHA-256 processor. It captures the 256-bit digest when the processor's level-type done signal rises, then streams the digest out MSB byte first over an 8-bit valid/ready interface. It feeds the narrow chip output pins and the host readout path. The digest can optionally be emitted as lowercase ASCII hex.

Parameters:
- OUT_BYTES, 32, number of leading digest bytes emitted per digest (1..32); allows a truncated digest.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- hash_in  in  256  digest from processor; bit 255 is the MSB of H0
- hash_done  in  1  processor done level; capture is triggered on its rising edge
- out_data  out  8  current output byte/char
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- out_last  out  1  high with the final byte/char of a digest
- busy  out  1  high while a digest is being streamed (state SEND)
- overrun  out  1  sticky; set when a digest is dropped

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, out_valid=0, out_last=0, out_data=0, busy=0, overrun=0, done_prev=0, count=0, shift register=0. Reset mid-stream aborts the stream; out_valid is 0 from the cycle after reset is sampled.
- Edge detect: done_prev <= hash_done every cycle; rise = hash_done && !done_prev. A level held high never retriggers.
- Define N_OUT = OUT_BYTES (raw mode) or 2*OUT_BYTES (ASCII mode).
- IDLE:
  - On rise: shift <= hash_in, count <= 0, state <= SEND.
  - out_valid=1 on the next cycle (latency 1 cycle from the sampled rise).
- SEND:
  - out_valid=1 and busy=1.
  - out_data = shift[255:248] in raw mode.
  - Transfer = out_valid && out_ready: shift left 8 (raw mode), count <= count+1.
  - out_last = (count == N_OUT-1), combinational from count.
  - out_data and out_last stay stable while out_valid && !out_ready.
- Transfer of the last item (out_last && out_ready):
  - If a rise occurs in the same cycle, the new digest is captured, count <= 0, and the state stays SEND. out_valid stays high with no bubble.
  - Otherwise state <= IDLE, and out_valid=0 the next cycle.
- Rise in SEND that is not the last-transfer cycle: the digest is dropped, the current stream continues unaffected, and overrun <= 1. overrun clears only on rst.
- count width is 7 bits and never exceeds N_OUT-1; no wrap.
- OUT_BYTES=1: a single transfer, with out_last=1 on it.
- Without the optional feature, only shift[255:256-8*OUT_BYTES] is emitted.

Optional Feature:
- Macro: SHA256_SER_HEX_ASCII_EN.
- Defined:
  - Each digest byte is emitted as two ASCII chars, high nibble first.
  - Nibble n maps to 8'h30+n for 0..9 and 8'h57+n for 10..15 (lowercase a-f).
  - Shift register shifts 4 bits per transfer; out_data = map(shift[255:252]).
  - N_OUT = 2*OUT_BYTES.
- Undefined: raw bytes, N_OUT = OUT_BYTES; no mapping logic is synthesized.

Test Plan:
1. Raw mode, always-ready sink: hash_in=SHA-256("abc")=ba7816bf...f20015ad, pulse hash_done high and hold it.
   - out_valid rises 1 cycle after the rise is sampled.
   - Bytes are 0xBA,0x78,0x16,0xBF,...,0x15,0xAD on 32 consecutive cycles.
   - out_last only on 0xAD; then out_valid=0 and busy=0.
   - The held hash_done does not retrigger.
2. Backpressure: same digest, out_ready toggled 1,0,0,1,...
   - Exactly 32 transfers in order; out_data/out_last stable during each stall; no byte skipped or duplicated.
3. Overrun: drop hash_done, then re-raise it mid-stream (count=10).
   - overrun=1 and stays 1; stream completes with the original digest.
   - A rise on the final-transfer cycle starts a new stream with no idle cycle, and overrun is unchanged by it.
4. Truncation: OUT_BYTES=4 with the "abc" digest.
   - Output 0xBA,0x78,0x16,0xBF with out_last on 0xBF; returns to IDLE.
5. Reset mid-stream: assert rst at count=5.
   - Next cycle: out_valid=0, busy=0, overrun=0.
   - A new rise after reset restarts from byte 0 (0xBA).
6. SHA256_SER_HEX_ASCII_EN defined, "abc" digest.
   - 64 chars beginning 0x62('b'),0x61('a'),0x37('7'),0x38('8') and ending 0x61('a'),0x64('d'), with out_last on the 64th.

Source files
------------

// File: rtl/sha256_digest_serializer.sv
// sha256_digest_serializer: captures a digest on the rising edge of hash_done and streams it MSB first over valid/ready.
// Define SHA256_SER_HEX_ASCII_EN to emit each byte as two lowercase ASCII hex chars.
module sha256_digest_serializer #(
    parameter int OUT_BYTES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] hash_in,
    input  logic         hash_done,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         busy,
    output logic         overrun
);
`ifdef SHA256_SER_HEX_ASCII_EN
    localparam int N_OUT = 2 * OUT_BYTES;
    localparam int STEP = 4;
`else
    localparam int N_OUT = OUT_BYTES;
    localparam int STEP = 8;
`endif
    localparam logic [6:0] LAST = 7'(N_OUT - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t       state_q, state_d;
    logic [255:0] shift_q, shift_d;
    logic [6:0]   count_q, count_d;
    logic         done_prev_q, overrun_q, overrun_d;
    logic         rise, send, xfer_last;

    assign send      = (state_q == SEND);
    assign rise      = hash_done && !done_prev_q;
    assign out_valid = send;
    assign busy      = send;
    assign overrun   = overrun_q;
    assign out_last  = send && (count_q == LAST);
    assign xfer_last = out_last && out_ready;

`ifdef SHA256_SER_HEX_ASCII_EN
    logic [3:0] nib;
    assign nib      = shift_q[255:252];
    assign out_data = !send ? 8'h00 : (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h57 + {4'h0, nib};
`else
    assign out_data = send ? shift_q[255:248] : 8'h00;
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        count_d   = count_q;
        overrun_d = overrun_q;
        if (!send) begin
            if (rise) begin
                shift_d = hash_in;
                count_d = 7'd0;
                state_d = SEND;
            end
        end else begin
            if (xfer_last) begin
                // A digest arriving exactly on the final transfer chains on without a bubble.
                shift_d = rise ? hash_in : shift_q;
                count_d = 7'd0;
                state_d = rise ? SEND : IDLE;
            end else if (out_ready) begin
                shift_d = shift_q << STEP;
                count_d = count_q + 7'd1;
            end
            if (rise && !xfer_last) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            count_q     <= '0;
            done_prev_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            done_prev_q <= hash_done;
            overrun_q   <= overrun_d;
        end
    end
endmodule

// File: tb/tb_sha256_digest_serializer.sv
// tb_sha256_digest_serializer: item-level reference model checked every cycle plus literal spot checks.
// Covers a full-length and a 4-byte truncated instance side by side.
module tb_sha256_digest_serializer;
    localparam logic [255:0] ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
`ifdef SHA256_SER_HEX_ASCII_EN
    localparam bit ASCII = 1'b1;
    localparam logic [7:0] FIRST = 8'h62, SECOND = 8'h61, LASTV = 8'h64, TRUNC_LAST = 8'h66;
`else
    localparam bit ASCII = 1'b0;
    localparam logic [7:0] FIRST = 8'hBA, SECOND = 8'h78, LASTV = 8'hAD, TRUNC_LAST = 8'hBF;
`endif

    logic clk = 1'b0, rst = 1'b1, hash_done = 1'b0, out_ready = 1'b1;
    logic [255:0] hash_in = '0;
    logic [7:0] od0, od1;
    logic ov0, ov1, ol0, ol1, bs0, bs1, or0, or1;
    int total = 0, bad = 0;
    bit chk_en = 1'b0;
    logic [7:0] q0[$];

    sha256_digest_serializer #(.OUT_BYTES(32)) u0 (
        .clk(clk), .rst(rst), .hash_in(hash_in), .hash_done(hash_done), .out_data(od0),
        .out_valid(ov0), .out_ready(out_ready), .out_last(ol0), .busy(bs0), .overrun(or0));
    sha256_digest_serializer #(.OUT_BYTES(4)) u1 (
        .clk(clk), .rst(rst), .hash_in(hash_in), .hash_done(hash_done), .out_data(od1),
        .out_valid(ov1), .out_ready(out_ready), .out_last(ol1), .busy(bs1), .overrun(or1));

    always #5 clk = ~clk;

    int nout[2] = '{ASCII ? 64 : 32, ASCII ? 8 : 4};
    bit m_act[2] = '{0, 0};
    bit m_ovr[2] = '{0, 0};
    int m_idx[2] = '{0, 0};
    logic [255:0] m_dig[2];
    bit m_prev = 1'b0;

    function automatic logic [7:0] item(logic [255:0] d, int i);
        logic [255:0] s;
        logic [3:0] n;
        if (ASCII) begin
            s = d << (4 * i);
            n = s[255:252];
            return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
        end
        s = d << (8 * i);
        return s[255:248];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        bit rise;
        rise = hash_done && !m_prev;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_act[k] = 0; m_idx[k] = 0; m_ovr[k] = 0;
            end else if (!m_act[k]) begin
                if (rise) begin m_act[k] = 1; m_dig[k] = hash_in; m_idx[k] = 0; end
            end else begin
                bit lastx;
                lastx = out_ready && (m_idx[k] == nout[k] - 1);
                if (rise && !lastx) m_ovr[k] = 1;
                if (lastx) begin
                    if (rise) begin m_dig[k] = hash_in; m_idx[k] = 0; end
                    else m_act[k] = 0;
                end else if (out_ready) m_idx[k]++;
            end
        end
        m_prev = rst ? 1'b0 : hash_done;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] od[2];
            logic ov[2], ol[2], bs[2], ovr[2];
            od = '{od0, od1}; ov = '{ov0, ov1}; ol = '{ol0, ol1}; bs = '{bs0, bs1}; ovr = '{or0, or1};
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("valid%0d", k), 32'(ov[k]), 32'(m_act[k]));
                chk($sformatf("busy%0d", k), 32'(bs[k]), 32'(m_act[k]));
                chk($sformatf("overrun%0d", k), 32'(ovr[k]), 32'(m_ovr[k]));
                chk($sformatf("data%0d", k), 32'(od[k]), m_act[k] ? 32'(item(m_dig[k], m_idx[k])) : 32'h0);
                chk($sformatf("last%0d", k), 32'(ol[k]), 32'(m_act[k] && m_idx[k] == nout[k] - 1));
            end
            if (ov0 && out_ready) q0.push_back(od0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while ((bs0 || bs1) && n < 400) begin step(); n++; end
        total++;
        if (bs0 || bs1) begin bad++; $display("FAIL %s: timeout waiting for idle", name); end
    endtask

    initial begin
        step(); step();
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_valid", 32'(ov0), 32'h0);
        chk("reset_overrun", 32'(or0), 32'h0);
        // Test 1: always-ready, hold done high
        hash_in = ABC; hash_done = 1'b1;
        q0.delete();
        step();
        chk("latency_valid", 32'(ov0), 32'h1);
        chk("first_byte", 32'(od0), 32'(FIRST));
        wait_idle("t1");
        chk("t1_count", q0.size(), 32'(nout[0]));
        if (q0.size() > 1) begin
            chk("t1_byte1", 32'(q0[1]), 32'(SECOND));
            chk("t1_lastbyte", 32'(q0[q0.size() - 1]), 32'(LASTV));
        end
        repeat (5) step();
        chk("no_retrigger", 32'(ov0), 32'h0);
        // Test 2: backpressure 1,0,0,...
        hash_done = 1'b0; step();
        hash_done = 1'b1;
        q0.delete();
        for (int i = 0; i < 300 && (i < 2 || bs0 || bs1); i++) begin
            out_ready = (i % 3 == 0);
            step();
        end
        out_ready = 1'b1;
        wait_idle("t2");
        chk("t2_count", q0.size(), 32'(nout[0]));
        if (q0.size() > 0) chk("t2_lastbyte", 32'(q0[q0.size() - 1]), 32'(LASTV));
        // Test 3: overrun mid-stream, then chained rise on the final transfer
        hash_done = 1'b0; step();
        hash_done = 1'b1; step();
        hash_done = 1'b0;
        for (int i = 0; i < 100 && !(m_act[0] && m_idx[0] == 10); i++) step();
        hash_done = 1'b1; step();
        chk("overrun_set", 32'(or0), 32'h1);
        hash_done = 1'b0;
        for (int i = 0; i < 100 && !(m_act[0] && m_idx[0] == nout[0] - 1); i++) step();
        chk("at_last", 32'(ol0), 32'h1);
        hash_in = ~ABC; hash_done = 1'b1; step();
        chk("chain_valid", 32'(ov0), 32'h1);
        chk("chain_first", 32'(od0), 32'(item(~ABC, 0)));
        chk("overrun_sticky", 32'(or0), 32'h1);
        hash_in = ABC;
        wait_idle("t3");
        // Test 4: truncated instance output observed alongside
        hash_done = 1'b0; step();
        hash_done = 1'b1;
        for (int i = 0; i < 20 && !(ol1 && ov1); i++) step();
        chk("trunc_last", 32'(od1), 32'(TRUNC_LAST));
        // Test 5: reset mid-stream
        hash_done = 1'b0;
        wait_idle("t4");
        step();
        hash_done = 1'b1;
        for (int i = 0; i < 50 && !(m_act[0] && m_idx[0] == 5); i++) step();
        rst = 1'b1; step();
        rst = 1'b0;
        chk("rst_valid", 32'(ov0), 32'h0);
        chk("rst_busy", 32'(bs0), 32'h0);
        chk("rst_overrun", 32'(or0), 32'h0);
        step();
        chk("restart_first", 32'(od0), 32'(FIRST));
        wait_idle("t5");
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
